// File: rtl/life_render_if.sv
// Pixel stream into the colouring stage and the colour/sync/population
// stream out of it; master drives pixels, slave renders them.
interface life_render_if #(
    parameter int HCOUNT_WIDTH   = 10,
    parameter int VCOUNT_WIDTH   = 10,
    parameter int LOG_BOARD_SIZE = 6
);
    logic [HCOUNT_WIDTH-1:0]     hcount_in;
    logic [VCOUNT_WIDTH-1:0]     vcount_in;
    logic                        hsync_in;
    logic                        vsync_in;
    logic                        blank_in;
    logic                        alive_in;
    logic [LOG_BOARD_SIZE-1:0]   cursor_x_in;
    logic [LOG_BOARD_SIZE-1:0]   cursor_y_in;
    logic                        hsync_out;
    logic                        vsync_out;
    logic                        blank_out;
    logic [11:0]                 rgb_out;
    logic [2*LOG_BOARD_SIZE:0]   pop_count_out;
    logic                        pop_valid_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in,
        output blank_in, alive_in, cursor_x_in, cursor_y_in,
        input  hsync_out, vsync_out, blank_out, rgb_out,
        input  pop_count_out, pop_valid_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in,
        input  blank_in, alive_in, cursor_x_in, cursor_y_in,
        output hsync_out, vsync_out, blank_out, rgb_out,
        output pop_count_out, pop_valid_out
    );
endinterface

// File: rtl/life_render.sv
// life_render: two-stage pixel colouring (cell/cursor/border) with a
// per-frame live-cell population count.
// Ports: clk_in, rst_n_in (async active-low), bus (life_render_if.slave):
//   pixel stream in (hcount/vcount/syncs/blank/alive/cursor), rgb and
//   syncs out 2 cycles later, pop_count_out/pop_valid_out per frame.
// Optional: define CURSOR_BLINK_EN to blink the cursor every
//   2**BLINK_LOG frames; otherwise the cursor is always drawn.
module life_render #(
    parameter int          BOARD_SIZE     = 64,
    parameter int          LOG_BOARD_SIZE = 6,
    parameter int          HCOUNT_WIDTH   = 10,
    parameter int          VCOUNT_WIDTH   = 10,
    parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
    parameter logic [11:0] DEAD_COLOR     = 12'h000,
    parameter logic [11:0] CURSOR_COLOR   = 12'hF00,
    parameter logic [11:0] BORDER_COLOR   = 12'h00F,
    parameter int          BLINK_LOG      = 5
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    life_render_if.slave  bus
);
    localparam int POP_W = 2*LOG_BOARD_SIZE+1;
    localparam logic [HCOUNT_WIDTH-1:0] H_BS =
        HCOUNT_WIDTH'(BOARD_SIZE);
    localparam logic [VCOUNT_WIDTH-1:0] V_BS =
        VCOUNT_WIDTH'(BOARD_SIZE);

    typedef enum logic {ST_FIRST, ST_RUN} state_t;

    state_t state_q, state_d;

    logic in_board_d, border_d, cursor_d;
    logic s1_in_board, s1_border, s1_cursor;
    logic s1_alive, s1_blank, s1_hsync, s1_vsync;
    logic [11:0] pix_color;
    logic cursor_vis;
    logic inc, frame_edge, pop_load;
    logic [POP_W-1:0] acc;

    assign in_board_d = (bus.hcount_in < H_BS)
                     && (bus.vcount_in < V_BS);
    assign border_d =
        ((bus.hcount_in == H_BS) && (bus.vcount_in <= V_BS)) ||
        ((bus.vcount_in == V_BS) && (bus.hcount_in <= H_BS));
    assign cursor_d =
        (bus.hcount_in == HCOUNT_WIDTH'(bus.cursor_x_in)) &&
        (bus.vcount_in == VCOUNT_WIDTH'(bus.cursor_y_in));

    // Stage 1: classify the pixel
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_in_board <= 1'b0;
            s1_border   <= 1'b0;
            s1_cursor   <= 1'b0;
            s1_alive    <= 1'b0;
            s1_blank    <= 1'b1;
            s1_hsync    <= 1'b1;
            s1_vsync    <= 1'b1;
        end else begin
            s1_in_board <= in_board_d;
            s1_border   <= border_d;
            s1_cursor   <= cursor_d;
            s1_alive    <= bus.alive_in;
            s1_blank    <= bus.blank_in;
            s1_hsync    <= bus.hsync_in;
            s1_vsync    <= bus.vsync_in;
        end
    end

    always_comb begin
        pix_color = 12'h000;
        if (s1_blank)
            pix_color = 12'h000;
        else if (s1_cursor && cursor_vis)
            pix_color = CURSOR_COLOR;
        else if (s1_border)
            pix_color = BORDER_COLOR;
        else if (s1_in_board && s1_alive)
            pix_color = ALIVE_COLOR;
        else if (s1_in_board)
            pix_color = DEAD_COLOR;
    end

    // Stage 2: colour and delayed syncs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.rgb_out   <= 12'h000;
            bus.hsync_out <= 1'b1;
            bus.vsync_out <= 1'b1;
            bus.blank_out <= 1'b1;
        end else begin
            bus.rgb_out   <= pix_color;
            bus.hsync_out <= s1_hsync;
            bus.vsync_out <= s1_vsync;
            bus.blank_out <= s1_blank;
        end
    end

    // Frame boundary: vsync asserting, seen against registered vsync
    assign frame_edge = s1_vsync & ~bus.vsync_in;
    assign inc = s1_in_board & ~s1_blank & s1_alive;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state_q <= ST_FIRST;
        else
            state_q <= state_d;
    end

    // The first edge after reset closes a partial frame: drop it
    always_comb begin
        state_d  = state_q;
        pop_load = 1'b0;
        if (frame_edge) begin
            if (state_q == ST_FIRST)
                state_d = ST_RUN;
            else
                pop_load = 1'b1;
        end
    end

    // Saturating accumulator; restarts from this cycle's increment
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            acc <= '0;
        else if (frame_edge)
            acc <= POP_W'(inc);
        else if (inc && (acc != {POP_W{1'b1}}))
            acc <= acc + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.pop_count_out <= '0;
            bus.pop_valid_out <= 1'b0;
        end else begin
            bus.pop_valid_out <= pop_load;
            if (pop_load)
                bus.pop_count_out <= acc;
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [BLINK_LOG:0] frame_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            frame_cnt <= '0;
        else if (pop_load)
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign cursor_vis = ~frame_cnt[BLINK_LOG];
`else
    assign cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_life_render.sv
// Directed bench for life_render: latency, colour priority,
// population count, saturation, reset and cursor blink.
module tb_life_render;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [12:0] last_pop = '0;

    always #5 clk = ~clk;

    life_render_if #(
        .HCOUNT_WIDTH(10),
        .VCOUNT_WIDTH(10),
        .LOG_BOARD_SIZE(6)
    ) bus ();

    life_render #(
        .BOARD_SIZE(64),
        .LOG_BOARD_SIZE(6),
        .HCOUNT_WIDTH(10),
        .VCOUNT_WIDTH(10),
        .BLINK_LOG(1)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (rst_n && bus.pop_valid_out) begin
            pulses++;
            last_pop = bus.pop_count_out;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v,
                         input logic a, input logic b,
                         input logic hs, input logic vs);
        bus.hcount_in = 10'(h);
        bus.vcount_in = 10'(v);
        bus.alive_in  = a;
        bus.blank_in  = b;
        bus.hsync_in  = hs;
        bus.vsync_in  = vs;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pix_chk(input string tag, input int h,
                           input int v, input logic a,
                           input logic b, input logic [11:0] exp);
        drive(h, v, a, b, 1'b1, 1'b1);
        step();
        drive(0, 200, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        check(tag, 32'(bus.rgb_out), 32'(exp));
    endtask

    task automatic run_frame(input int mode);
        int gx[5] = '{1, 2, 0, 1, 2};
        int gy[5] = '{0, 1, 2, 2, 2};
        if (mode == 0) begin
            for (int i = 0; i < 5; i++) begin
                drive(gx[i], gy[i], 1'b1, 1'b0, 1'b1, 1'b1);
                step();
                drive(30 + i, 30, 1'b0, 1'b0, 1'b1, 1'b1);
                step();
            end
            drive(3, 3, 1'b1, 1'b1, 1'b1, 1'b1);
            step();
        end else begin
            for (int r = 0; r < mode * 2 - 1; r++)
                for (int v = 0; v < 64; v++)
                    for (int h = 0; h < 64; h++) begin
                        drive(h, v, 1'b1, 1'b0, 1'b1, 1'b1);
                        step();
                    end
        end
    endtask

    task automatic end_frame();
        drive(0, 480, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) step();
        drive(0, 490, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step();
        drive(0, 493, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) step();
    endtask

    initial begin
        int edges;
        int cnt;
        logic [11:0] exp;
        bus.cursor_x_in = 6'd10;
        bus.cursor_y_in = 6'd10;
        drive(5, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        repeat (3) step();
        check("rst_rgb", 32'(bus.rgb_out), 0);
        check("rst_hs", 32'(bus.hsync_out), 1);
        check("rst_vs", 32'(bus.vsync_out), 1);
        check("rst_blank", 32'(bus.blank_out), 1);
        check("rst_pop", 32'(bus.pop_count_out), 0);
        check("rst_popv", 32'(bus.pop_valid_out), 0);

        rst_n = 1'b1;
        drive(5, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("lat1_rgb", 32'(bus.rgb_out), 0);
        check("lat1_hs", 32'(bus.hsync_out), 1);
        drive(100, 100, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        check("lat2_rgb", 32'(bus.rgb_out), 32'hFFF);
        check("lat2_hs", 32'(bus.hsync_out), 0);
        check("lat2_blank", 32'(bus.blank_out), 0);
        step();
        check("lat3_rgb", 32'(bus.rgb_out), 0);
        check("lat3_hs", 32'(bus.hsync_out), 1);

        pix_chk("alive_5_7", 5, 7, 1'b1, 1'b0, 12'hFFF);
        pix_chk("cursor", 10, 10, 1'b0, 1'b0, 12'hF00);
        pix_chk("dead_6_7", 6, 7, 1'b0, 1'b0, 12'h000);
        pix_chk("border_64_3", 64, 3, 1'b0, 1'b0, 12'h00F);
        pix_chk("border_3_64", 3, 64, 1'b0, 1'b0, 12'h00F);
        pix_chk("border_corner", 64, 64, 1'b0, 1'b0, 12'h00F);
        pix_chk("out_65_3", 65, 3, 1'b0, 1'b0, 12'h000);
        pix_chk("out_64_65", 64, 65, 1'b0, 1'b0, 12'h000);
        pix_chk("blank_alive", 3, 3, 1'b1, 1'b1, 12'h000);

        run_frame(0);
        end_frame();
        check("first_edge_pulses", 32'(pulses), 0);
        check("first_edge_pop", 32'(bus.pop_count_out), 0);
        run_frame(0);
        end_frame();
        check("glider1_pulses", 32'(pulses), 1);
        check("glider1_pop", 32'(last_pop), 5);
        run_frame(0);
        end_frame();
        check("glider2_pulses", 32'(pulses), 2);
        check("glider2_pop", 32'(last_pop), 5);
        check("popv_low", 32'(bus.pop_valid_out), 0);

        run_frame(1);
        end_frame();
        check("full_pulses", 32'(pulses), 3);
        check("full_pop", 32'(last_pop), 4096);
        run_frame(2);
        end_frame();
        check("sat_pop", 32'(last_pop), 8191);
        run_frame(0);
        end_frame();
        check("after_sat_pop", 32'(last_pop), 5);
        check("after_sat_pulses", 32'(pulses), 5);

        drive(5, 7, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pop", 32'(bus.pop_count_out), 0);
        check("mid_rst_rgb", 32'(bus.rgb_out), 0);
        check("mid_rst_blank", 32'(bus.blank_out), 1);
        step();
        rst_n = 1'b1;

        edges = 0;
        for (int k = 0; k < 7; k++) begin
            cnt = (edges == 0) ? 0 : ((edges - 1) % 4);
`ifdef CURSOR_BLINK_EN
            exp = (((cnt >> 1) & 1) == 0) ? 12'hF00 : 12'hFFF;
`else
            exp = 12'hF00;
`endif
            pix_chk($sformatf("blink_f%0d_c%0d", k, cnt),
                    10, 10, 1'b1, 1'b0, exp);
            end_frame();
            edges++;
            if (k == 0)
                check("blink_first_pulses", 32'(pulses), 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
